branch_resolution_unit: RTL and testbench

- Consumer-side counterpart to the 2-bit branch predictor.
- Holds in-flight branch predictions issued by fetch in an in-order queue and compares each one against the outcome reported by execute.
- Returns `branch_resolved`/`branch_taken_actual` update pulses to the predictor.
- On a misprediction, drives pipeline flush and PC redirect.

---
 rtl/branch_resolution_unit.sv | 172 +++++++++++++++++
 tb/tb_branch_resolution_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: keeps an in-order queue of in-flight branch
// predictions, checks each one against the outcome reported by execute,
// pulses predictor updates, and on a mispredict squashes the queue, flushes
// the pipeline for FLUSH_CYCLES cycles and redirects fetch.
module branch_resolution_unit #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PC_W         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    input  logic [PC_W-1:0]              pred_target,
    input  logic [PC_W-1:0]              pred_fallthru,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic                         res_taken,
    input  logic [PC_W-1:0]              res_target,
    output logic                         branch_resolved,
    output logic                         branch_taken_actual,
    output logic                         flush,
    output logic                         redirect_valid,
    output logic [PC_W-1:0]              redirect_pc,
    output logic [15:0]                  mispredict_count,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         err_underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            r_state;
    logic [FC_W-1:0]   r_fcnt;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_q_taken    [DEPTH];
    logic [PC_W-1:0]   r_q_target   [DEPTH];
    logic [PC_W-1:0]   r_q_fallthru [DEPTH];

    logic              r_resolved;
    logic              r_taken_actual;
    logic              r_flush;
    logic              r_redirect_valid;
    logic [PC_W-1:0]   r_redirect_pc;
    logic [15:0]       r_mispredict_count;
    logic              r_err_underflow;

    logic              w_run;
    logic              w_ready;
    logic              w_pop;
    logic              w_underflow;
    logic              w_mis;
    logic              w_push_eff;
    logic              w_head_taken;
    logic [PC_W-1:0]   w_head_target;
    logic [PC_W-1:0]   w_head_fallthru;

    // Handshake, head-of-queue compare and event qualification
    always_comb begin
        w_run           = (r_state == ST_RUN);
        w_ready         = w_run && (r_count < CNT_W'(DEPTH));
        w_head_taken    = r_q_taken[r_rptr];
        w_head_target   = r_q_target[r_rptr];
        w_head_fallthru = r_q_fallthru[r_rptr];
        w_pop           = res_valid && w_run && (r_count != '0);
        w_underflow     = res_valid && w_run && (r_count == '0);
        w_mis           = w_pop && ((w_head_taken != res_taken) ||
                          (res_taken && w_head_taken && (w_head_target != res_target)));
        // A push coinciding with a mispredict belongs to the squashed path
        w_push_eff      = pred_valid && w_ready && !w_mis;
    end

    // Prediction storage; validity is tracked by the pointers and occupancy
    always_ff @(posedge clk) begin
        if (w_push_eff) begin
            r_q_taken[r_wptr]    <= pred_taken;
            r_q_target[r_wptr]   <= pred_target;
            r_q_fallthru[r_wptr] <= pred_fallthru;
        end
    end

    // Queue pointers, FSM, update pulses, redirect and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= ST_RUN;
            r_fcnt             <= '0;
            r_wptr             <= '0;
            r_rptr             <= '0;
            r_count            <= '0;
            r_resolved         <= 1'b0;
            r_taken_actual     <= 1'b0;
            r_flush            <= 1'b0;
            r_redirect_valid   <= 1'b0;
            r_redirect_pc      <= '0;
            r_mispredict_count <= '0;
            r_err_underflow    <= 1'b0;
        end else begin
            r_resolved       <= w_pop;
            r_taken_actual   <= w_pop && res_taken;
            r_redirect_valid <= w_mis;
            if (w_mis) begin
                r_redirect_pc <= res_taken ? res_target : w_head_fallthru;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end

            case (r_state)
                ST_RUN: begin
                    if (w_mis) begin
                        r_state <= ST_FLUSH;
                        r_flush <= 1'b1;
                        r_fcnt  <= FC_W'(FLUSH_CYCLES - 1);
                        if (r_mispredict_count != 16'hFFFF) begin
                            r_mispredict_count <= r_mispredict_count + 16'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (r_fcnt == '0) begin
                        r_state <= ST_RUN;
                        r_flush <= 1'b0;
                    end else begin
                        r_fcnt <= r_fcnt - FC_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_flush <= 1'b0;
                end
            endcase

            if (w_mis) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push_eff) begin
                    r_wptr <= r_wptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PTR_W'(1);
                end
                if (w_push_eff && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push_eff && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    assign pred_ready          = w_ready;
    assign outstanding         = r_count;
    assign branch_resolved     = r_resolved;
    assign branch_taken_actual = r_taken_actual;
    assign flush               = r_flush;
    assign redirect_valid      = r_redirect_valid;
    assign redirect_pc         = r_redirect_pc;
    assign mispredict_count    = r_mispredict_count;
    assign err_underflow       = r_err_underflow;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Testbench for branch_resolution_unit: directed steps with a transaction
// model of the prediction queue; expected update pulses are queued when a
// resolve is driven and checked when the unit pulses.
module tb_branch_resolution_unit;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned PC_W         = 32;
    localparam int unsigned FLUSH_CYCLES = 2;

    logic                        clk = 1'b0;
    logic                        reset_n = 1'b0;
    logic                        pred_valid = 1'b0;
    logic                        pred_taken = 1'b0;
    logic [PC_W-1:0]             pred_target = '0;
    logic [PC_W-1:0]             pred_fallthru = '0;
    logic                        pred_ready;
    logic                        res_valid = 1'b0;
    logic                        res_taken = 1'b0;
    logic [PC_W-1:0]             res_target = '0;
    logic                        branch_resolved;
    logic                        branch_taken_actual;
    logic                        flush;
    logic                        redirect_valid;
    logic [PC_W-1:0]             redirect_pc;
    logic [15:0]                 mispredict_count;
    logic [$clog2(DEPTH+1)-1:0]  outstanding;
    logic                        err_underflow;

    branch_resolution_unit #(
        .DEPTH(DEPTH),
        .PC_W(PC_W),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .pred_fallthru(pred_fallthru),
        .pred_ready(pred_ready),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .res_target(res_target),
        .branch_resolved(branch_resolved),
        .branch_taken_actual(branch_taken_actual),
        .flush(flush),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .mispredict_count(mispredict_count),
        .outstanding(outstanding),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [31:0] fallthru;
    } pred_t;

    typedef struct {
        logic        taken;
        logic        mis;
        logic [31:0] pc;
    } exp_t;

    pred_t       mq[$];
    exp_t        sb[$];
    int          fl = 0;
    logic        m_err = 1'b0;
    logic [15:0] m_mc = '0;
    logic [31:0] m_rpc = '0;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check handshake, model the cycle, drive, clock, check results
    task automatic cyc(input logic pv, input logic pt, input logic [31:0] ptg,
                       input logic [31:0] pft, input logic rv, input logic rt,
                       input logic [31:0] rtg);
        logic  ready;
        logic  mis;
        pred_t h;
        pred_t p;
        exp_t  e;
        ready = (fl == 0) && (mq.size() < DEPTH);
        chk1("pred_ready", pred_ready, ready);
        chk32("outstanding_pre", 32'(outstanding), 32'(mq.size()));
        mis = 1'b0;
        if (rv && fl == 0) begin
            if (mq.size() == 0) begin
                m_err = 1'b1;
            end else begin
                h = mq.pop_front();
                mis = (h.taken != rt) || (rt && h.taken && (h.target != rtg));
                e.taken = rt;
                e.mis   = mis;
                e.pc    = rt ? rtg : h.fallthru;
                sb.push_back(e);
                if (mis) begin
                    mq.delete();
                    if (m_mc != 16'hFFFF) m_mc++;
                end
            end
        end
        if (pv && ready && !mis) begin
            p.taken = pt; p.target = ptg; p.fallthru = pft;
            mq.push_back(p);
        end
        if (fl > 0) fl--;
        if (mis) fl = FLUSH_CYCLES;

        pred_valid = pv; pred_taken = pt; pred_target = ptg; pred_fallthru = pft;
        res_valid = rv; res_taken = rt; res_target = rtg;
        @(posedge clk);
        #1;
        pred_valid = 1'b0; res_valid = 1'b0;

        chk1("branch_resolved", branch_resolved, sb.size() != 0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk1("branch_taken_actual", branch_taken_actual, e.taken);
            chk1("redirect_valid", redirect_valid, e.mis);
            if (e.mis) m_rpc = e.pc;
        end else begin
            chk1("redirect_valid_idle", redirect_valid, 1'b0);
        end
        chk32("redirect_pc", redirect_pc, m_rpc);
        chk1("flush", flush, fl > 0);
        chk1("err_underflow", err_underflow, m_err);
        chk32("mispredict_count", 32'(mispredict_count), 32'(m_mc));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held across clock edges
        reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk1("rst_branch_resolved", branch_resolved, 1'b0);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_redirect_valid", redirect_valid, 1'b0);
        chk32("rst_redirect_pc", redirect_pc, 32'h0);
        chk32("rst_mispredict_count", 32'(mispredict_count), 32'h0);
        chk1("rst_err_underflow", err_underflow, 1'b0);
        chk32("rst_outstanding", 32'(outstanding), 32'h0);
        reset_n = 1'b1;
        idle(1);

        // Correct not-taken prediction
        cyc(1, 0, 32'h100, 32'h104, 0, 0, 0);
        chk32("t1_outstanding", 32'(outstanding), 32'd1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk1("t1_resolved", branch_resolved, 1'b1);
        chk1("t1_taken_actual", branch_taken_actual, 1'b0);
        chk1("t1_flush", flush, 1'b0);
        chk32("t1_outstanding_after", 32'(outstanding), 32'd0);
        idle(1);

        // Predicted not-taken, actually taken; resolve during flush is ignored
        cyc(1, 0, 32'h200, 32'h204, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h400);
        chk1("t2_redirect_valid", redirect_valid, 1'b1);
        chk32("t2_redirect_pc", redirect_pc, 32'h400);
        chk32("t2_mispredict_count", 32'(mispredict_count), 32'd1);
        chk1("t2_pred_ready_f1", pred_ready, 1'b0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk1("t2_pred_ready_f2", pred_ready, 1'b0);
        chk1("t2_flush_f2", flush, 1'b1);
        idle(1);
        chk1("t2_flush_done", flush, 1'b0);
        chk1("t2_pred_ready_back", pred_ready, 1'b1);

        // Taken with wrong target; push in the same cycle is squashed
        cyc(1, 1, 32'h300, 32'h304, 0, 0, 0);
        cyc(1, 0, 32'h700, 32'h704, 1, 1, 32'h310);
        chk32("t3_redirect_pc", redirect_pc, 32'h310);
        chk1("t3_taken_actual", branch_taken_actual, 1'b1);
        chk32("t3_outstanding", 32'(outstanding), 32'd0);
        idle(2);

        // Fill the queue, refused fifth push, mispredict on the oldest
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'h1000 + 32'(i) * 32'h10, 32'h2000 + 32'(i) * 32'h10, 0, 0, 0);
        chk1("t4_full_ready", pred_ready, 1'b0);
        cyc(1, 1, 32'h900, 32'h904, 0, 0, 0);
        chk32("t4_full_outstanding", 32'(outstanding), 32'd4);
        cyc(0, 0, 0, 0, 1, 1, 32'h500);
        chk32("t4_outstanding", 32'(outstanding), 32'd0);
        chk32("t4_redirect_pc", redirect_pc, 32'h500);
        idle(4);

        // Resolve with an empty queue
        cyc(0, 0, 0, 0, 1, 1, 32'h600);
        chk1("t5_err", err_underflow, 1'b1);
        chk1("t5_no_pulse", branch_resolved, 1'b0);
        idle(2);
        chk1("t5_err_sticky", err_underflow, 1'b1);

        // Simultaneous push and correct resolve, then wrap with back-to-back pairs
        cyc(1, 1, 32'h3000, 32'h3004, 0, 0, 0);
        cyc(1, 0, 32'h3100, 32'h3104, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            cyc(1, i[0], 32'h4000 + 32'(i) * 32'h10, 32'h5000 + 32'(i) * 32'h10,
                1, mq[0].taken, mq[0].target);
            chk32("t6_outstanding", 32'(outstanding), 32'd2);
        end
        cyc(0, 0, 0, 0, 1, mq[0].taken, mq[0].target);
        cyc(0, 0, 0, 0, 1, mq[0].taken, mq[0].target);
        chk32("t6_drained", 32'(outstanding), 32'd0);
        idle(1);

        // Asynchronous reset in the middle of a flush
        cyc(1, 1, 32'h800, 32'h804, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk1("t7_flush_before", flush, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("t7_flush_async", flush, 1'b0);
        chk1("t7_err_async", err_underflow, 1'b0);
        chk32("t7_mc_async", 32'(mispredict_count), 32'h0);
        chk32("t7_redirect_pc_async", redirect_pc, 32'h0);
        chk1("t7_redirect_valid_async", redirect_valid, 1'b0);
        mq.delete(); sb.delete();
        fl = 0; m_err = 1'b0; m_mc = '0; m_rpc = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(1);
        cyc(1, 0, 32'hA00, 32'hA04, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(1);

        chk32("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
